// File: rtl/uop_group_queue.sv
// uop_group_queue: circular micro-op buffer between the instruction cracker
// and the rename/decode stage. Accepts up to WIDTH micro-ops per cycle and
// offers exactly WIDTH-wide groups; a partial group is released, padded with
// NOP_UOP, after PAD_TIMEOUT idle cycles. Cleared by flush on redirect.
module uop_group_queue #(
    parameter int unsigned      WIDTH       = 4,
    parameter int unsigned      DEPTH       = 16,
    parameter int unsigned      UOP_W       = 24,
    parameter logic [UOP_W-1:0] NOP_UOP     = '0,
    parameter int unsigned      PAD_TIMEOUT = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [WIDTH*UOP_W-1:0]       in_uops,
    input  logic [$clog2(WIDTH+1)-1:0]   in_count,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH*UOP_W-1:0]       out_uops,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned TMR_W = (PAD_TIMEOUT > 1) ? $clog2(PAD_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_PAD  = 2'd2
    } state_e;

    logic [UOP_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] pad_n_q, pad_n_d;
    state_e           state_q, state_d;

    logic             full_offer;
    logic             enq_fire;
    logic             deq_fire;
    logic [CNT_W-1:0] n_enq;
    logic [CNT_W-1:0] n_deq;

    // Handshakes and per-cycle transfer counts from registered state
    always_comb begin
        in_ready   = !flush && (occ_q <= OCC_W'(DEPTH - WIDTH));
        full_offer = (state_q != S_PAD) && (occ_q >= OCC_W'(WIDTH));
        out_valid  = full_offer || (state_q == S_PAD);
        enq_fire   = in_valid && in_ready;
        deq_fire   = out_valid && out_ready && !flush;
        n_enq      = '0;
        if (enq_fire) begin
            n_enq = (in_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : in_count;
        end
        n_deq = '0;
        if (deq_fire) begin
            n_deq = (state_q == S_PAD) ? pad_n_q : CNT_W'(WIDTH);
        end
    end

    // Next-state: pointers, occupancy, grouping FSM and pad timer
    always_comb begin
        head_d  = head_q + PTR_W'(n_deq);
        tail_d  = tail_q + PTR_W'(n_enq);
        occ_d   = occ_q + OCC_W'(n_enq) - OCC_W'(n_deq);
        state_d = state_q;
        timer_d = timer_q;
        pad_n_d = pad_n_q;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            occ_d   = '0;
            state_d = S_IDLE;
            timer_d = '0;
        end else if (state_q == S_PAD && !deq_fire) begin
            // Committed padded group stays frozen until the decoder takes it
            state_d = S_PAD;
        end else if (occ_d == '0) begin
            state_d = S_IDLE;
            timer_d = '0;
        end else if (occ_d < OCC_W'(WIDTH)) begin
            state_d = S_WAIT;
            if (state_q == S_WAIT && !deq_fire) begin
                if (timer_q == TMR_W'(PAD_TIMEOUT - 1)) begin
                    state_d = S_PAD;
                    pad_n_d = CNT_W'(occ_d);
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end else begin
                timer_d = '0;
            end
        end else begin
            // Enough for a full group: offer it, timer parked at zero
            state_d = S_WAIT;
            timer_d = '0;
        end
    end

    // Control state register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            state_q <= S_IDLE;
            timer_q <= '0;
            pad_n_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            state_q <= state_d;
            timer_q <= timer_d;
            pad_n_q <= pad_n_d;
        end
    end

    // Storage write: accepted uops land at tail in MS-to-LS slot order
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < WIDTH; k++) begin
            if (CNT_W'(k) < n_enq) begin
                mem_q[tail_q + PTR_W'(k)] <= in_uops[(WIDTH-1-k)*UOP_W +: UOP_W];
            end
        end
    end

    // Output group: head entries in valid slots, NOP_UOP elsewhere
    always_comb begin
        out_uops = {WIDTH{NOP_UOP}};
        for (int unsigned k = 0; k < WIDTH; k++) begin
            if (full_offer || (state_q == S_PAD && CNT_W'(k) < pad_n_q)) begin
                out_uops[(WIDTH-1-k)*UOP_W +: UOP_W] = mem_q[head_q + PTR_W'(k)];
            end
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_uop_group_queue.sv
// Directed self-checking bench for uop_group_queue (WIDTH=4, DEPTH=16,
// UOP_W=24, NOP_UOP=0, PAD_TIMEOUT=3).
module tb_uop_group_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [95:0] in_uops = '0;
    logic [2:0]  in_count = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [95:0] out_uops;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  occupancy;

    int total = 0;
    int bad = 0;

    uop_group_queue #(
        .WIDTH(4), .DEPTH(16), .UOP_W(24), .NOP_UOP(24'h0), .PAD_TIMEOUT(3)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_uops(in_uops), .in_count(in_count), .in_valid(in_valid),
        .in_ready(in_ready), .out_uops(out_uops), .out_valid(out_valid),
        .out_ready(out_ready), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] seqgrp(input logic [23:0] v);
        return {v, 24'(v + 1), 24'(v + 2), 24'(v + 3)};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++; if (occupancy !== 5'd0) begin bad++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (out_uops !== 96'h0) begin bad++; $display("FAIL reset_out_uops: got %h want 0", out_uops); end
    endtask

    task automatic test_full_group();
        out_ready = 1'b1;
        in_uops = {24'h0000A1, 24'h0000B2, 24'h0000C3, 24'h0000D4};
        in_count = 3'd4;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL full_valid: got %b want 1", out_valid); end
        total++; if (out_uops !== {24'h0000A1, 24'h0000B2, 24'h0000C3, 24'h0000D4}) begin bad++; $display("FAIL full_uops: got %h want A1 B2 C3 D4", out_uops); end
        total++; if (occupancy !== 5'd4) begin bad++; $display("FAIL full_occ: got %0d want 4", occupancy); end
        tick();
        total++; if (occupancy !== 5'd0) begin bad++; $display("FAIL full_drained_occ: got %0d want 0", occupancy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_drained_valid: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_pad_release();
        out_ready = 1'b1;
        in_uops = {24'h00AAAA, 24'h00BBBB, 24'hBADBAD, 24'hBADBAD};
        in_count = 3'd2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pad_wait_%0d: got out_valid %b want 0", i, out_valid); end
            total++; if (occupancy !== 5'd2) begin bad++; $display("FAIL pad_wait_occ_%0d: got %0d want 2", i, occupancy); end
            tick();
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pad_release_valid: got %b want 1", out_valid); end
        total++; if (out_uops !== {24'h00AAAA, 24'h00BBBB, 24'h0, 24'h0}) begin bad++; $display("FAIL pad_release_uops: got %h want AAAA BBBB 0 0", out_uops); end
        tick();
        total++; if (occupancy !== 5'd0) begin bad++; $display("FAIL pad_accept_occ: got %0d want 0", occupancy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pad_accept_valid: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_pad_hold();
        out_ready = 1'b0;
        in_uops = {24'h0000A1, 24'h0000B2, 24'h0, 24'h0};
        in_count = 3'd2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        total++; if (out_uops !== {24'h0000A1, 24'h0000B2, 24'h0, 24'h0}) begin bad++; $display("FAIL hold_pad_uops: got %h want A1 B2 0 0", out_uops); end
        in_uops = {24'h0000C3, 24'h0000D4, 24'h0000E5, 24'hBADBAD};
        in_count = 3'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (out_uops !== {24'h0000A1, 24'h0000B2, 24'h0, 24'h0}) begin bad++; $display("FAIL hold_after_enq_uops: got %h want A1 B2 0 0", out_uops); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_after_enq_valid: got %b want 1", out_valid); end
        total++; if (occupancy !== 5'd5) begin bad++; $display("FAIL hold_after_enq_occ: got %0d want 5", occupancy); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (occupancy !== 5'd3) begin bad++; $display("FAIL hold_accept_occ: got %0d want 3", occupancy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_accept_valid: got %b want 0", out_valid); end
        tick(); tick(); tick();
        total++; if (out_uops !== {24'h0000C3, 24'h0000D4, 24'h0000E5, 24'h0}) begin bad++; $display("FAIL hold_second_pad: got %h want C3 D4 E5 0", out_uops); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (occupancy !== 5'd0) begin bad++; $display("FAIL hold_drain_occ: got %0d want 0", occupancy); end
    endtask

    task automatic test_count_edges();
        out_ready = 1'b0;
        in_uops = {24'h000011, 24'h000022, 24'h000033, 24'h000044};
        in_count = 3'd0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (occupancy !== 5'd0) begin bad++; $display("FAIL count0_occ: got %0d want 0", occupancy); end
        tick(); tick(); tick(); tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL count0_no_pad: got %b want 0", out_valid); end
        in_count = 3'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (occupancy !== 5'd4) begin bad++; $display("FAIL clamp_occ: got %0d want 4", occupancy); end
        total++; if (out_uops !== {24'h000011, 24'h000022, 24'h000033, 24'h000044}) begin bad++; $display("FAIL clamp_uops: got %h want 11 22 33 44", out_uops); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (occupancy !== 5'd0) begin bad++; $display("FAIL clamp_drain_occ: got %0d want 0", occupancy); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] rd = 24'h000200;
        logic [23:0] wr = 24'h000200;
        out_ready = 1'b1;
        in_count = 3'd4;
        in_valid = 1'b1;
        in_uops = seqgrp(wr);
        tick();
        wr = wr + 24'd4;
        for (int i = 0; i < 5; i++) begin
            in_uops = seqgrp(wr);
            total++; if (out_uops !== seqgrp(rd)) begin bad++; $display("FAIL b2b_uops_%0d: got %h want %h", i, out_uops, seqgrp(rd)); end
            total++; if (occupancy !== 5'd4) begin bad++; $display("FAIL b2b_occ_%0d: got %0d want 4", i, occupancy); end
            tick();
            wr = wr + 24'd4;
            rd = rd + 24'd4;
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        total++; if (occupancy !== 5'd0) begin bad++; $display("FAIL b2b_drain_occ: got %0d want 0", occupancy); end
    endtask

    task automatic test_wrap();
        logic [23:0] rd = 24'h000100;
        logic [23:0] wr = 24'h000100;
        int exp_occ = 13;
        bit acc;
        out_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            in_count = (b == 3) ? 3'd1 : 3'd4;
            in_uops = seqgrp(wr);
            in_valid = 1'b1;
            tick();
            wr = wr + ((b == 3) ? 24'd1 : 24'd4);
        end
        in_valid = 1'b0;
        total++; if (occupancy !== 5'd13) begin bad++; $display("FAIL wrap_fill_occ: got %0d want 13", occupancy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL wrap_full_in_ready: got %b want 0", in_ready); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL wrap_full_valid: got %b want 1", out_valid); end
        out_ready = 1'b1;
        in_count = 3'd4;
        for (int i = 0; i < 12; i++) begin
            in_uops = seqgrp(wr);
            in_valid = 1'b1;
            acc = (exp_occ <= 12);
            total++; if (out_uops !== seqgrp(rd)) begin bad++; $display("FAIL wrap_uops_%0d: got %h want %h", i, out_uops, seqgrp(rd)); end
            tick();
            rd = rd + 24'd4;
            if (acc) wr = wr + 24'd4;
            exp_occ = exp_occ - 4 + (acc ? 4 : 0);
            total++; if (occupancy !== 5'(exp_occ)) begin bad++; $display("FAIL wrap_occ_%0d: got %0d want %0d", i, occupancy, exp_occ); end
        end
        in_valid = 1'b0;
        while (exp_occ >= 4) begin
            total++; if (out_uops !== seqgrp(rd)) begin bad++; $display("FAIL wrap_drain_uops: got %h want %h", out_uops, seqgrp(rd)); end
            tick();
            rd = rd + 24'd4;
            exp_occ = exp_occ - 4;
        end
        total++; if (occupancy !== 5'd1) begin bad++; $display("FAIL wrap_tail_occ: got %0d want 1", occupancy); end
        tick(); tick(); tick();
        total++; if (out_uops !== {rd, 24'h0, 24'h0, 24'h0}) begin bad++; $display("FAIL wrap_last_pad: got %h want %h", out_uops, {rd, 72'h0}); end
        tick();
        out_ready = 1'b0;
        total++; if (occupancy !== 5'd0) begin bad++; $display("FAIL wrap_end_occ: got %0d want 0", occupancy); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_count = 3'd4;
        in_valid = 1'b1;
        in_uops = seqgrp(24'h0000F0);
        tick();
        in_uops = seqgrp(24'h0000F4);
        tick();
        in_valid = 1'b0;
        total++; if (occupancy !== 5'd8) begin bad++; $display("FAIL flush_pre_occ: got %0d want 8", occupancy); end
        flush = 1'b1;
        in_valid = 1'b1;
        in_uops = seqgrp(24'h000300);
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        total++; if (occupancy !== 5'd0) begin bad++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        total++; if (out_uops !== 96'h0) begin bad++; $display("FAIL flush_uops: got %h want 0", out_uops); end
        in_uops = seqgrp(24'h000400);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (out_uops !== seqgrp(24'h000400)) begin bad++; $display("FAIL flush_refill_uops: got %h want %h", out_uops, seqgrp(24'h000400)); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_count = 3'd4;
        in_uops = seqgrp(24'h000500);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (occupancy !== 5'd4) begin bad++; $display("FAIL arst_pre_occ: got %0d want 4", occupancy); end
        #2 rst = 1'b1;
        #1;
        total++; if (occupancy !== 5'd0) begin bad++; $display("FAIL arst_occ: got %0d want 0", occupancy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b want 0", out_valid); end
        tick();
        rst = 1'b0;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_in_ready: got %b want 1", in_ready); end
    endtask

    initial begin
        #2;
        test_reset();
        test_full_group();
        test_pad_release();
        test_pad_hold();
        test_count_edges();
        test_back_to_back();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
